// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, result entry type and parity helper for the subtract unit and its consumers.
package alu_pkg;
    localparam int RESULT_W  = 32;
    localparam int OPERAND_W = 5;

    typedef struct packed {
        logic [RESULT_W-1:0] result;
        logic                balance;
        logic                err;
    } alu_result_t;

    function automatic logic even_parity5(input logic [OPERAND_W-1:0] x);
        return ~^x;
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones, with synchronous clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && !(&q))
            q <= q + W'(1);
    end
endmodule

// File: rtl/alu_result_collector.sv
// alu_result_collector: checks subtract-unit results for parity/sign-extension consistency,
// buffers them in a small FIFO toward the consumer and keeps saturating statistics.
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [RESULT_W-1:0] in_result,
    input  logic                in_balance,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RESULT_W-1:0] out_result,
    output logic                out_balance,
    output logic                out_err,
    output logic [CNT_W-1:0]    total_cnt,
    output logic [CNT_W-1:0]    err_cnt
);
    localparam int AW = $clog2(DEPTH);

    alu_result_t   mem [DEPTH];
    alu_result_t   entry;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, par_ok, sext_ok;

    always_comb begin
        par_ok   = in_balance == even_parity5(in_result[OPERAND_W-1:0]);
        sext_ok  = in_result[RESULT_W-1:OPERAND_W] == {(RESULT_W-OPERAND_W){in_result[OPERAND_W-1]}};
        entry    = '{result: in_result, balance: in_balance, err: !(par_ok && sext_ok)};
        in_ready = count != (AW+1)'(DEPTH);
        out_valid = count != '0;
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
    end

    // storage is cleared on reset so the stale head reads zero until the first push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign out_result  = mem[rd_ptr].result;
    assign out_balance = mem[rd_ptr].balance;
    assign out_err     = mem[rd_ptr].err;

    sat_counter #(.W(CNT_W)) u_total (
        .clk(clk), .rst_n(rst_n), .inc(push), .clr(1'b0), .q(total_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err (
        .clk(clk), .rst_n(rst_n), .inc(push && entry.err), .clr(1'b0), .q(err_cnt)
    );
endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector: directed vectors with a queue scoreboard checked at every falling edge.
module tb_alu_result_collector;
    import alu_pkg::*;

    logic        clk = 0, rst_n = 0, in_valid = 0, in_balance = 0, out_ready = 0;
    logic [31:0] in_result = 0;
    logic        in_ready, out_valid, out_balance, out_err;
    logic [31:0] out_result;
    logic [15:0] total_cnt, err_cnt;

    alu_result_t exp_in = '0;
    alu_result_t q[$];
    int vec = 0, mis = 0, m_total = 0, m_err = 0;

    always #5 clk = ~clk;

    alu_result_collector #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_result(in_result),
        .in_balance(in_balance), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_balance(out_balance),
        .out_err(out_err), .total_cnt(total_cnt), .err_cnt(err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: expected FIFO contents and counters, advanced with the same push/pop rule
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_total = 0;
            m_err   = 0;
        end else begin
            automatic logic rdy = q.size() < 4;
            automatic logic vld = q.size() != 0;
            chk("in_ready", 32'(in_ready), 32'(rdy));
            chk("out_valid", 32'(out_valid), 32'(vld));
            if (vld) begin
                chk("out_result", out_result, q[0].result);
                chk("out_balance", 32'(out_balance), 32'(q[0].balance));
                chk("out_err", 32'(out_err), 32'(q[0].err));
            end
            chk("total_cnt", 32'(total_cnt), 32'(m_total));
            chk("err_cnt", 32'(err_cnt), 32'(m_err));
            if (vld && out_ready)
                void'(q.pop_front());
            if (in_valid && rdy) begin
                q.push_back(exp_in);
                m_total++;
                if (exp_in.err) m_err++;
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] r, input logic b, input logic e, input logic rdy);
        @(posedge clk);
        #1;
        in_valid   = v;
        in_result  = r;
        in_balance = b;
        exp_in     = '{result: r, balance: b, err: e};
        out_ready  = rdy;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++)
            drive(0, 32'h0, 0, 0, rdy);
    endtask

    // asserts reset between edges and checks that it takes effect without a clock
    task automatic do_reset;
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_total_cnt", 32'(total_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    logic [31:0] pp_res [12] = '{32'h00000000, 32'hFFFFFFE0, 32'h00000007, 32'hFFFFFFF0,
                                 32'h0000000F, 32'h0000000F, 32'hFFFFFFF8, 32'h00000020,
                                 32'h00000009, 32'hFFFFFFFE, 32'h0000000A, 32'h7FFFFFF1};
    logic        pp_bal [12] = '{1, 1, 0, 0, 1, 0, 1, 1, 1, 0, 1, 1};
    logic        pp_err [12] = '{0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1};
    logic        seq_bal [5] = '{0, 0, 1, 0, 1};

    initial begin
        do_reset();
        drive(1, 32'h00000005, 1, 0, 1);
        idle(2, 1);
        drive(1, 32'hFFFFFFFF, 0, 0, 1);
        drive(1, 32'hFFFFFFFF, 1, 1, 1);
        drive(1, 32'h00000015, 0, 1, 1);
        idle(3, 1);
        for (int i = 1; i <= 4; i++)
            drive(1, 32'(i), seq_bal[i-1], 0, 0);
        for (int i = 0; i < 3; i++)
            drive(1, 32'd5, seq_bal[4], 0, 0);
        for (int i = 0; i < 2; i++)
            drive(1, 32'd5, seq_bal[4], 0, 1);
        idle(6, 1);
        for (int i = 0; i < 2; i++)
            drive(1, pp_res[i], pp_bal[i], pp_err[i], 0);
        for (int i = 2; i < 12; i++)
            drive(1, pp_res[i], pp_bal[i], pp_err[i], 1);
        idle(4, 1);
        do_reset();
        drive(1, 32'h00000003, 1, 0, 0);
        drive(1, 32'h00000015, 0, 1, 0);
        drive(1, 32'hFFFFFFFF, 1, 1, 0);
        idle(2, 0);
        do_reset();
        drive(1, 32'h00000009, 1, 0, 1);
        idle(3, 1);
        chk("drained", 32'(q.size()), 32'd0);
        chk("final_total", 32'(total_cnt), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
